// File: rtl/adder32_slice_seq.sv
// Multi-cycle WIDTH-bit adder that time-shares one external SLICE-bit adder.
// Operands are walked LSB-first through the slice; the result is returned by valid/ready.
module adder32_slice_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [SLICE-1:0] slc_a,
    output logic [SLICE-1:0] slc_b,
    output logic             slc_cin,
    input  logic [SLICE:0]   slc_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [IW-1:0]    idx_q, idx_d;

    // Operands shift down and the accumulator fills from the top, so the
    // current slice is always the low SLICE bits and no wide mux is needed.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    c_d     = in_cin;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                acc_d = {slc_sum[SLICE-1:0], acc_q[WIDTH-1:SLICE]};
                c_d   = slc_sum[SLICE];
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_valid ? {c_q, acc_q} : '0;
    assign slc_a     = busy ? a_q[SLICE-1:0] : '0;
    assign slc_b     = busy ? b_q[SLICE-1:0] : '0;
    assign slc_cin   = busy & c_q;

endmodule

// File: tb/tb_adder32_slice_seq.sv
// Randomized and directed bench for adder32_slice_seq with an exact or stub slice.
// The reference is plain integer addition of the operands.
module tb_adder32_slice_seq;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [SLICE-1:0] slc_a;
    logic [SLICE-1:0] slc_b;
    logic             slc_cin;
    logic [SLICE:0]   slc_sum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             busy;

    logic stub;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   prev_t0;
    int   prev_hold;
    bit   have_prev;

    adder32_slice_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin),
        .slc_sum(slc_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared slice: exact adder, or a stub returning a fixed pattern.
    assign slc_sum = stub ? 5'b1_0101
                          : {1'b0, slc_a} + {1'b0, slc_b} + {4'b0, slc_cin};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input int hold, input bit keep_valid);
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] nib_a;
        logic [WIDTH-1:0] nib_b;
        int waits;
        int t0;
        exp = stub ? 33'h1_5555_5555
                   : {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        waits = 0;
        while (!in_ready && waits < 50) begin
            step();
            waits++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        out_ready = (hold == 0);
        step();
        t0 = cyc;
        if (have_prev)
            chk("accept_gap", 64'(t0 - prev_t0), 64'(NSLICE + 2 + prev_hold));
        prev_t0 = t0;
        prev_hold = hold;
        have_prev = 1'b1;
        in_valid = keep_valid;
        for (int i = 0; i < NSLICE; i++) begin
            nib_a = a >> (SLICE * i);
            nib_b = b >> (SLICE * i);
            chk("run_busy", 64'(busy), 64'd1);
            chk("run_in_ready", 64'(in_ready), 64'd0);
            chk("run_out_valid", 64'(out_valid), 64'd0);
            chk("slc_a", 64'(slc_a), 64'(nib_a[SLICE-1:0]));
            chk("slc_b", 64'(slc_b), 64'(nib_b[SLICE-1:0]));
            if (i == 0) chk("slc_cin0", 64'(slc_cin), 64'(cin));
            step();
        end
        chk("done_valid", 64'(out_valid), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("out_sum", 64'(out_sum), 64'(exp));
        chk("done_slc_a", 64'(slc_a), 64'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_sum", 64'(out_sum), 64'(exp));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("post_in_ready", 64'(in_ready), 64'd1);
        chk("post_valid", 64'(out_valid), 64'd0);
        chk("post_sum", 64'(out_sum), 64'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] nib;
        int hold;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b0;
        stub = 1'b0;
        have_prev = 1'b0;
        prev_t0 = 0;
        prev_hold = 0;
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_slc", 64'({slc_a, slc_b, slc_cin}), 64'd0);
        rst = 1'b0;
        step();

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 1'b0);
        stub = 1'b1;
        run_op(32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b0, 0, 1'b0);
        stub = 1'b0;
        run_op(32'hCAFE_0001, 32'h3501_FFFF, 1'b1, 5, 1'b1);
        run_op(32'hCAFE_0001, 32'h3501_FFFF, 1'b1, 0, 1'b0);

        // Abort mid-RUN while slice 3 is presented.
        in_a = 32'h8765_4321;
        in_b = 32'h1111_1111;
        in_cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        nib = in_a >> (SLICE * 3);
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_slc_a", 64'(slc_a), 64'(nib[SLICE-1:0]));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_sum", 64'(out_sum), 64'd0);
        chk("abort_busy0", 64'(busy), 64'd0);
        have_prev = 1'b0;
        run_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 0, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            ra = $urandom;
            rb = $urandom;
            hold = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 3));
            run_op(ra, rb, 1'($urandom % 2), hold, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
